hicore_de2issue_buf: RTL and testbench

Two-entry decoupling FIFO between the decode stage and the issue dispatcher, carrying the packed de2issue word (unit-select bits, ROB pointer, operand/control payload, excp/irq/pc tail) unchanged. It breaks the combinational ready path from the execution units back into decode, absorbs one cycle of back-pressure without bubbles, and generates the issue-side cancel on pipeline flush. Downstream consumer is the issue dispatcher; upstream producer is the decoder.

---
 rtl/hicore_de2issue_buf.sv | 135 +++++++++++++
 tb/tb_hicore_de2issue_buf.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hicore_de2issue_buf.sv
// ============================================================================
// hicore_de2issue_buf
// ----------------------------------------------------------------------------
// Two-entry decoupling FIFO between the decoder and the issue dispatcher.
// It carries the packed de2issue word unchanged. It breaks the combinational
// ready path from the execution units back into decode. It absorbs one cycle
// of back-pressure without bubbles. It also raises the issue-side cancel on a
// pipeline flush.
//
// Optional feature macro: HICORE_DE2ISSUE_BYPASS_EN
//   When defined, a word arriving at an empty buffer is presented to the
//   dispatcher in the same cycle. If the dispatcher takes it, nothing is
//   written. When undefined, the buffer is strictly registered, with a
//   minimum latency of one cycle.
//
// Parameters:
//   DATA_W             width of the carried de2issue word
//
// Ports:
//   clk                core clock, rising edge
//   rst_n              asynchronous active-low reset
//   i_dec_valid        decoder presents a word
//   o_dec_ready        buffer can accept (occupancy below two)
//   i_dec_info         decoded word
//   o_de2issue_valid   head entry valid
//   i_de2issue_ready   dispatcher accepts the head
//   o_de2issue_info    head entry payload
//   o_de2issue_cancel  flush while a word is being presented
//   i_flush            pipeline flush
//   o_count            current occupancy, 0..2
// ============================================================================
`ifndef HiCore_DE2ISSUE_SIZE
`define HiCore_DE2ISSUE_SIZE 64
`endif

module hicore_de2issue_buf #(
   parameter int DATA_W = `HiCore_DE2ISSUE_SIZE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_dec_valid,
   output logic              o_dec_ready,
   input  logic [DATA_W-1:0] i_dec_info,
   output logic              o_de2issue_valid,
   input  logic              i_de2issue_ready,
   output logic [DATA_W-1:0] o_de2issue_info,
   output logic              o_de2issue_cancel,
   input  logic              i_flush,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] entry [2];
   logic              wptr;
   logic              rptr;
   logic [1:0]        count;
   logic              enq;
   logic              deq;
   logic              stored_valid;

   // Input readiness depends only on registered occupancy. A dequeue in the
   // same cycle therefore never reopens the input, which keeps the
   // dispatcher's ready signal off the decoder's timing path.
   always_comb begin
      o_dec_ready  = (count != 2'd2);
      stored_valid = (count != 2'd0);
      o_count      = count;
   end

`ifdef HICORE_DE2ISSUE_BYPASS_EN
   logic bypass_active;
   logic bypass_take;

   // In bypass mode an empty buffer forwards the decoder word straight to
   // the dispatcher. If the dispatcher takes it in that cycle, the word is
   // consumed without being stored. Otherwise it is enqueued as usual.
   always_comb begin
      bypass_active     = (count == 2'd0) & i_dec_valid;
      bypass_take       = bypass_active & i_de2issue_ready & ~i_flush;
      o_de2issue_valid  = stored_valid | bypass_active;
      o_de2issue_info   = stored_valid ? entry[rptr] : i_dec_info;
      o_de2issue_cancel = i_flush & o_de2issue_valid;
      enq               = i_dec_valid & o_dec_ready & ~i_flush & ~bypass_take;
      deq               = stored_valid & i_de2issue_ready & ~i_flush;
   end
`else
   // The default build is purely registered. The head entry is presented
   // whenever the buffer holds anything. A flush suppresses both enqueue and
   // dequeue, because everything in flight is being discarded.
   always_comb begin
      o_de2issue_valid  = stored_valid;
      o_de2issue_info   = entry[rptr];
      o_de2issue_cancel = i_flush & o_de2issue_valid;
      enq               = i_dec_valid & o_dec_ready & ~i_flush;
      deq               = stored_valid & i_de2issue_ready & ~i_flush;
   end
`endif

   // Pointers and occupancy. A flush empties the buffer and realigns both
   // pointers to slot 0. The one-bit pointers wrap from 1 to 0 naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
      end else if (i_flush) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (enq) begin
            wptr <= ~wptr;
         end
         if (deq) begin
            rptr <= ~rptr;
         end
         if (enq && !deq) begin
            count <= count + 2'd1;
         end else if (deq && !enq) begin
            count <= count - 2'd1;
         end
      end
   end

   // Entry storage. Entries are cleared only by reset. A flush leaves them
   // intact, since a zero occupancy already marks them as invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry[0] <= '0;
         entry[1] <= '0;
      end else if (enq) begin
         entry[wptr] <= i_dec_info;
      end
   end

endmodule

// File: tb/tb_hicore_de2issue_buf.sv
// ============================================================================
// tb_hicore_de2issue_buf
// ----------------------------------------------------------------------------
// Self-checking bench for hicore_de2issue_buf. A queue-based reference model
// tracks what the buffer should hold. Directed scenarios are followed by a
// randomized run, and every comparison is made inline.
// ============================================================================
`timescale 1ns/1ps

module tb_hicore_de2issue_buf;

   localparam int DW = 64;

   logic          clk;
   logic          rst_n;
   logic          dec_valid;
   logic          dec_ready;
   logic [DW-1:0] dec_info;
   logic          iss_valid;
   logic          iss_ready;
   logic [DW-1:0] iss_info;
   logic          iss_cancel;
   logic          flush;
   logic [1:0]    count;

   int checks;
   int errors;

   logic [DW-1:0] mq[$];
   int            msz;
   logic          mtake;
   logic          menq;
   logic          mdeq;

   hicore_de2issue_buf #(.DATA_W(DW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_dec_valid       (dec_valid),
      .o_dec_ready       (dec_ready),
      .i_dec_info        (dec_info),
      .o_de2issue_valid  (iss_valid),
      .i_de2issue_ready  (iss_ready),
      .o_de2issue_info   (iss_info),
      .o_de2issue_cancel (iss_cancel),
      .i_flush           (flush),
      .o_count           (count)
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The reference model holds the words the buffer should contain, oldest
   // first. It is a FIFO of depth two that empties on a flush.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else begin
         msz = mq.size();
         if (flush) begin
            mq.delete();
         end else begin
`ifdef HICORE_DE2ISSUE_BYPASS_EN
            mtake = (msz == 0) && dec_valid && iss_ready;
`else
            mtake = 1'b0;
`endif
            menq = dec_valid && (msz < 2) && !mtake;
            mdeq = (msz > 0) && iss_ready;
            if (mdeq) void'(mq.pop_front());
            if (menq) mq.push_back(dec_info);
         end
      end
   end

   function automatic logic exp_valid();
`ifdef HICORE_DE2ISSUE_BYPASS_EN
      return (mq.size() != 0) || dec_valid;
`else
      return mq.size() != 0;
`endif
   endfunction

   function automatic logic [DW-1:0] exp_info();
      if (mq.size() != 0) return mq[0];
      return dec_info;
   endfunction

   function automatic logic exp_ready();
      return mq.size() != 2;
   endfunction

   function automatic logic [1:0] exp_count();
      return 2'(mq.size());
   endfunction

   task automatic idle_inputs();
      dec_valid = 1'b0;
      dec_info  = '0;
      iss_ready = 1'b0;
      flush     = 1'b0;
   endtask

   // Fill the buffer to two entries while the dispatcher is stalled.
   task automatic fill_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
      dec_valid = 1'b1; iss_ready = 1'b0; dec_info = a;
      @(negedge clk);
      dec_info = b;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset();
      fill_two(64'h1111, 64'h2222);
      #1;
      checks++;
      if (count !== 2'd2) begin
         errors++; $display("[TB] FAIL reset_prefill count got %0d want 2", count);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (iss_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_valid got %b want 0", iss_valid);
      end
      checks++;
      if (dec_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_ready got %b want 1", dec_ready);
      end
      checks++;
      if (count !== 2'd0) begin
         errors++; $display("[TB] FAIL reset_count got %0d want 0", count);
      end
      checks++;
      if (iss_info !== '0) begin
         errors++; $display("[TB] FAIL reset_info got %h want 0", iss_info);
      end
      checks++;
      if (iss_cancel !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_cancel got %b want 0", iss_cancel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_streaming();
      logic [DW-1:0] want;
      int first_cyc;
      want = 1;
      first_cyc = -1;
      for (int c = 0; c < 12; c++) begin
         dec_valid = (c < 8);
         dec_info  = DW'(c + 1);
         iss_ready = 1'b1;
         #1;
         if (iss_valid) begin
            if (first_cyc < 0) first_cyc = c;
            checks++;
            if (iss_info !== want) begin
               errors++; $display("[TB] FAIL stream_data got %h want %h", iss_info, want);
            end
            want++;
         end
         checks++;
         if (count > 2'd1) begin
            errors++; $display("[TB] FAIL stream_count got %0d want <=1", count);
         end
         @(negedge clk);
      end
      idle_inputs();
      checks++;
      if (want !== DW'(9)) begin
         errors++; $display("[TB] FAIL stream_total got %0d want 8", want - 1);
      end
`ifdef HICORE_DE2ISSUE_BYPASS_EN
      checks++;
      if (first_cyc !== 0) begin
         errors++; $display("[TB] FAIL stream_latency got %0d want 0", first_cyc);
      end
`else
      checks++;
      if (first_cyc !== 1) begin
         errors++; $display("[TB] FAIL stream_latency got %0d want 1", first_cyc);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] exp_seq[3];
      int got;
      exp_seq[0] = 64'hA; exp_seq[1] = 64'hB; exp_seq[2] = 64'hC;
      fill_two(64'hA, 64'hB);
      dec_valid = 1'b1; dec_info = 64'hC; iss_ready = 1'b0;
      #1;
      checks++;
      if (count !== 2'd2) begin
         errors++; $display("[TB] FAIL bp_count got %0d want 2", count);
      end
      checks++;
      if (dec_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_ready got %b want 0", dec_ready);
      end
      @(negedge clk);
      got = 0;
      iss_ready = 1'b1;
      for (int c = 0; c < 10 && got < 3; c++) begin
         #1;
         if (iss_valid) begin
            checks++;
            if (iss_info !== exp_seq[got]) begin
               errors++; $display("[TB] FAIL bp_order got %h want %h", iss_info, exp_seq[got]);
            end
            got++;
         end
         if (dec_valid && dec_ready) begin
            @(negedge clk);
            dec_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (got !== 3) begin
         errors++; $display("[TB] FAIL bp_delivered got %0d want 3", got);
      end
      #1;
      checks++;
      if (iss_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_drained got %b want 0", iss_valid);
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_full_simultaneous();
      fill_two(64'h31, 64'h32);
      dec_valid = 1'b1; dec_info = 64'h33; iss_ready = 1'b1;
      #1;
      checks++;
      if (dec_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL fullsim_ready_now got %b want 0", dec_ready);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (count !== 2'd1) begin
         errors++; $display("[TB] FAIL fullsim_count got %0d want 1", count);
      end
      checks++;
      if (dec_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL fullsim_ready_next got %b want 1", dec_ready);
      end
      checks++;
      if (iss_info !== 64'h32) begin
         errors++; $display("[TB] FAIL fullsim_head got %h want 32", iss_info);
      end
      iss_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_flush();
      fill_two(64'h41, 64'h42);
      dec_valid = 1'b1; dec_info = 64'h43; flush = 1'b1; iss_ready = 1'b1;
      #1;
      checks++;
      if (iss_cancel !== 1'b1) begin
         errors++; $display("[TB] FAIL flush_cancel got %b want 1", iss_cancel);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (iss_valid !== 1'b0 || count !== 2'd0) begin
         errors++; $display("[TB] FAIL flush_empty got v=%b c=%0d want v=0 c=0", iss_valid, count);
      end
      dec_valid = 1'b1; dec_info = 64'h55;
      @(negedge clk);
      dec_valid = 1'b0;
`ifdef HICORE_DE2ISSUE_BYPASS_EN
      dec_valid = 1'b0;
`endif
      #1;
      checks++;
      if (iss_valid !== 1'b1 || iss_info !== 64'h55 || count !== 2'd1) begin
         errors++; $display("[TB] FAIL flush_next got v=%b d=%h c=%0d want v=1 d=55 c=1", iss_valid, iss_info, count);
      end
      iss_ready = 1'b1;
      @(negedge clk);
      iss_ready = 1'b0;
      #1;
      checks++;
      if (iss_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL flush_alone got %b want 0", iss_valid);
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [DW-1:0] sent[$];
      int got;
      got = 0;
      dec_valid = 1'b1; dec_info = 64'h60; iss_ready = 1'b0;
      sent.push_back(64'h60);
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         if (c % 2 == 0) begin
            dec_valid = 1'b1; dec_info = DW'(64'h61 + c / 2); iss_ready = 1'b0;
            sent.push_back(dec_info);
         end else begin
            dec_valid = 1'b0; iss_ready = 1'b1;
         end
         #1;
         checks++;
         if (count !== ((c % 2 == 0) ? 2'd1 : 2'd2)) begin
            errors++; $display("[TB] FAIL wrap_count got %0d at step %0d", count, c);
         end
         if (iss_valid && iss_ready) begin
            checks++;
            if (iss_info !== sent[got]) begin
               errors++; $display("[TB] FAIL wrap_order got %h want %h", iss_info, sent[got]);
            end
            got++;
         end
         @(negedge clk);
      end
      idle_inputs();
      iss_ready = 1'b1;
      @(negedge clk);
      iss_ready = 1'b0;
      checks++;
      if (got !== 5) begin
         errors++; $display("[TB] FAIL wrap_delivered got %0d want 5", got);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         dec_valid = ($urandom_range(0, 3) != 0);
         dec_info  = {$urandom, $urandom};
         iss_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         #1;
         checks++;
         if (iss_valid !== exp_valid()) begin
            errors++; $display("[TB] FAIL rand_valid got %b want %b", iss_valid, exp_valid());
         end
         checks++;
         if (dec_ready !== exp_ready() || count !== exp_count()) begin
            errors++; $display("[TB] FAIL rand_occ got r=%b c=%0d want r=%b c=%0d", dec_ready, count, exp_ready(), exp_count());
         end
         checks++;
         if (iss_cancel !== (flush & exp_valid())) begin
            errors++; $display("[TB] FAIL rand_cancel got %b want %b", iss_cancel, flush & exp_valid());
         end
         if (exp_valid()) begin
            checks++;
            if (iss_info !== exp_info()) begin
               errors++; $display("[TB] FAIL rand_info got %h want %h", iss_info, exp_info());
            end
         end
         @(negedge clk);
      end
      idle_inputs();
      @(negedge clk);
   endtask

   // The directed scenarios run first, followed by the randomized
   // comparison against the queue model.
   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();
      rst_n = 1'b0;
      #12 rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_streaming();
      test_backpressure();
      test_full_simultaneous();
      test_flush();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
